// File: rtl/iir_biquad_mc.sv
// Time-multiplexed direct-form-I biquad shared by NUM_CH channels.
// One MAC step per cycle (b0,b1,b2,a1,a2), then a rounding/saturating output cycle.
module iir_biquad_mc #(
    parameter int DW     = 10,
    parameter int CW     = 16,
    parameter int CFRAC  = 14,
    parameter int NUM_CH = 4,
    parameter int CHW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHW-1:0]        in_ch,
    input  logic signed [DW-1:0]  in_data,
    input  logic                  bypass,
    input  logic                  coef_we,
    input  logic [2:0]            coef_addr,
    input  logic signed [CW-1:0]  coef_data,
    input  logic                  coef_commit,
    input  logic                  hist_clr,
    output logic                  out_valid,
    output logic [CHW-1:0]        out_ch,
    output logic signed [DW-1:0]  out_data,
    output logic                  ch_err
);
    localparam int AW = DW + CW + 3;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CHW:0]    NCH  = (CHW + 1)'(NUM_CH);
    localparam logic [CW-1:0]   ONE  = {{(CW - 1){1'b0}}, 1'b1} << CFRAC;
    localparam logic [AW-1:0]   HALF = {{(AW - 1){1'b0}}, 1'b1} << (CFRAC - 1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             tap_q, tap_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic signed [DW-1:0]   x_q, x_d;
    logic                   byp_q, byp_d;
    logic signed [DW-1:0]   hx1_q, hx1_d, hx2_q, hx2_d, hy1_q, hy1_d, hy2_q, hy2_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic                   discard_q, discard_d;
    logic                   pend_q, pend_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [CHW-1:0]         out_ch_q, out_ch_d;
    logic signed [DW-1:0]   out_data_q, out_data_d;
    logic                   ch_err_q, ch_err_d;
    logic signed [CW-1:0]   sh_q [5];
    logic signed [CW-1:0]   sh_d [5];
    logic signed [CW-1:0]   act_q [5];
    logic signed [CW-1:0]   act_d [5];
    logic signed [DW-1:0]   x1_q [NUM_CH];
    logic signed [DW-1:0]   x1_d [NUM_CH];
    logic signed [DW-1:0]   x2_q [NUM_CH];
    logic signed [DW-1:0]   x2_d [NUM_CH];
    logic signed [DW-1:0]   y1_q [NUM_CH];
    logic signed [DW-1:0]   y1_d [NUM_CH];
    logic signed [DW-1:0]   y2_q [NUM_CH];
    logic signed [DW-1:0]   y2_d [NUM_CH];

    logic                   accept, ch_bad, commit_now;
    logic [IW-1:0]          in_idx, ch_idx;
    logic signed [DW-1:0]   mac_samp;
    logic signed [CW-1:0]   mac_coef;
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]   prod_ext, rnd, y_full;
    logic signed [DW-1:0]   y_sat, y_out;

    assign accept   = in_valid & in_ready_q;
    assign ch_bad   = ({1'b0, in_ch} >= NCH);
    assign in_idx   = in_ch[IW-1:0];
    assign ch_idx   = ch_q[IW-1:0];

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;
    assign ch_err    = ch_err_q;

    // Operand select for the shared multiplier; history comes from the copy latched at accept.
    always_comb begin
        mac_samp = '0;
        mac_coef = '0;
        case (tap_q)
            3'd0: begin mac_samp = x_q;   mac_coef = act_q[0]; end
            3'd1: begin mac_samp = hx1_q; mac_coef = act_q[1]; end
            3'd2: begin mac_samp = hx2_q; mac_coef = act_q[2]; end
            3'd3: begin mac_samp = hy1_q; mac_coef = act_q[3]; end
            3'd4: begin mac_samp = hy2_q; mac_coef = act_q[4]; end
            default: begin mac_samp = '0; mac_coef = '0; end
        endcase
    end

    assign prod     = mac_samp * mac_coef;
    assign prod_ext = {{(AW - DW - CW){prod[DW+CW-1]}}, prod};

    // Round half toward +inf, then saturate when the discarded high bits are not pure sign.
    assign rnd    = acc_q + $signed(HALF);
    assign y_full = rnd >>> CFRAC;
    always_comb begin
        y_sat = y_full[DW-1:0];
        if (!((&y_full[AW-1:DW-1]) || !(|y_full[AW-1:DW-1]))) begin
            y_sat = y_full[AW-1] ? {1'b1, {(DW - 1){1'b0}}} : {1'b0, {(DW - 1){1'b1}}};
        end
    end
    assign y_out = byp_q ? x_q : y_sat;

    // Coefficient banks: shadow writes always land; active copy only in an idle, non-accept cycle.
    assign commit_now = (state_q == S_IDLE) && !accept && (coef_commit || pend_q);
    always_comb begin
        sh_d  = sh_q;
        act_d = act_q;
        pend_d = pend_q;
        if (coef_we && (coef_addr < 3'd5)) begin
            sh_d[coef_addr] = coef_data;
        end
        if (commit_now) begin
            act_d  = sh_d;
            pend_d = 1'b0;
        end else if (coef_commit) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        ch_d        = ch_q;
        x_d         = x_q;
        byp_d       = byp_q;
        hx1_d       = hx1_q;
        hx2_d       = hx2_q;
        hy1_d       = hy1_q;
        hy2_d       = hy2_q;
        acc_d       = acc_q;
        discard_d   = discard_q;
        in_ready_d  = in_ready_q;
        out_valid_d = 1'b0;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        ch_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (accept && ch_bad) begin
                    ch_err_d = 1'b1;
                end else if (accept) begin
                    state_d    = S_MAC;
                    in_ready_d = 1'b0;
                    tap_d      = 3'd0;
                    acc_d      = '0;
                    ch_d       = in_ch;
                    x_d        = in_data;
                    byp_d      = bypass;
                    hx1_d      = x1_q[in_idx];
                    hx2_d      = x2_q[in_idx];
                    hy1_d      = y1_q[in_idx];
                    hy2_d      = y2_q[in_idx];
                    discard_d  = hist_clr;
                end
            end
            S_MAC: begin
                acc_d = (tap_q >= 3'd3) ? acc_q - prod_ext : acc_q + prod_ext;
                tap_d = tap_q + 3'd1;
                if (tap_q == 3'd4) begin
                    state_d = S_DONE;
                end
                if (hist_clr) begin
                    discard_d = 1'b1;
                end
            end
            S_DONE: begin
                out_valid_d = 1'b1;
                out_ch_d    = ch_q;
                out_data_d  = y_out;
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-channel history: clear beats update; a cleared-in-flight sample never writes back.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hist
            logic hit;
            assign hit = (state_q == S_DONE) && !discard_q && (ch_idx == IW'(gi));
            assign x1_d[gi] = hist_clr ? '0 : (hit ? x_q       : x1_q[gi]);
            assign x2_d[gi] = hist_clr ? '0 : (hit ? x1_q[gi]  : x2_q[gi]);
            assign y1_d[gi] = hist_clr ? '0 : (hit ? y_out     : y1_q[gi]);
            assign y2_d[gi] = hist_clr ? '0 : (hit ? y1_q[gi]  : y2_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tap_q       <= '0;
            ch_q        <= '0;
            x_q         <= '0;
            byp_q       <= 1'b0;
            hx1_q       <= '0;
            hx2_q       <= '0;
            hy1_q       <= '0;
            hy2_q       <= '0;
            acc_q       <= '0;
            discard_q   <= 1'b0;
            pend_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            ch_err_q    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                sh_q[i]  <= (i == 0) ? $signed(ONE) : '0;
                act_q[i] <= (i == 0) ? $signed(ONE) : '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            ch_q        <= ch_d;
            x_q         <= x_d;
            byp_q       <= byp_d;
            hx1_q       <= hx1_d;
            hx2_q       <= hx2_d;
            hy1_q       <= hy1_d;
            hy2_q       <= hy2_d;
            acc_q       <= acc_d;
            discard_q   <= discard_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            ch_err_q    <= ch_err_d;
            sh_q        <= sh_d;
            act_q       <= act_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            y1_q        <= y1_d;
            y2_q        <= y2_d;
        end
    end
endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: passthrough, gain/saturation, rounding, bypass,
// recursion, mid-flight commit, bad channel and reset abort.
module tb_iir_biquad_mc;
    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_ch;
    logic signed [9:0]  in_data;
    logic               bypass;
    logic               coef_we;
    logic [2:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               coef_commit;
    logic               hist_clr;
    logic               out_valid;
    logic [2:0]         out_ch;
    logic signed [9:0]  out_data;
    logic               ch_err;

    int n_checks = 0;
    int n_fail   = 0;

    iir_biquad_mc #(.DW(10), .CW(16), .CFRAC(14), .NUM_CH(4), .CHW(3)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .hist_clr(hist_clr),
        .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .ch_err(ch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic signed [15:0] data);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = addr; coef_data = data;
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        coef_commit = 1'b1;
        @(posedge clk); #1;
        coef_commit = 1'b0;
    endtask

    // One sample: accept, then watch 10 edges. lat = edges from accept to out_valid (-1 if none).
    task automatic sample(input logic [2:0] ch, input logic signed [9:0] x, input logic byp,
                          input logic mid, input logic signed [15:0] mdata,
                          output int lat, output int nv, output logic signed [9:0] y,
                          output logic [2:0] och, output logic err);
        int g;
        lat = -1; nv = 0; y = '0; och = '0; g = 0;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        in_valid = 1'b1; in_ch = ch; in_data = x; bypass = byp;
        @(posedge clk); #1;
        in_valid = 1'b0; bypass = 1'b0;
        err = ch_err;
        for (int k = 1; k <= 10; k++) begin
            if (mid && k == 2) begin
                coef_we = 1'b1; coef_addr = 3'd0; coef_data = mdata; coef_commit = 1'b1;
            end
            @(posedge clk); #1;
            coef_we = 1'b0; coef_commit = 1'b0;
            if (out_valid) begin
                nv++;
                if (lat < 0) begin
                    lat = k; y = out_data; och = out_ch;
                end
            end
        end
    endtask

    int lat, nv;
    logic signed [9:0] y;
    logic [2:0] och;
    logic err;
    logic signed [9:0] exp_imp;
    int nv_abort;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; bypass = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0; hist_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_ch_err", ch_err, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", in_ready, 1);

        // Passthrough after reset
        sample(3'd0, 10'sd100, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=100 -> y=%0d lat=%0d", y, lat);
        check("pass100_y", y, 100);
        check("pass100_ch", och, 0);
        check("pass100_lat", lat, 6);
        check("pass100_pulse", nv, 1);
        sample(3'd0, -10'sd512, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=-512 -> y=%0d lat=%0d", y, lat);
        check("pass_neg_y", y, -512);
        check("pass_neg_lat", lat, 6);

        // Gain 1.5 with saturation
        write_coef(3'd0, 16'sd24576);
        commit();
        sample(3'd0, 10'sd511, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=511 -> y=%0d", y);
        check("sat_pos", y, 511);
        sample(3'd0, -10'sd512, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=-512 -> y=%0d", y);
        check("sat_neg", y, -512);
        sample(3'd0, 10'sd200, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=200 -> y=%0d", y);
        check("gain_200", y, 300);

        // Gain 0.5 rounding, then bypass
        write_coef(3'd0, 16'sd8192);
        commit();
        sample(3'd0, 10'sd3, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=3 -> y=%0d", y);
        check("round_pos", y, 2);
        sample(3'd0, -10'sd3, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=-3 -> y=%0d", y);
        check("round_neg", y, -1);
        sample(3'd0, 10'sd101, 1'b1, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 bypass x=101 -> y=%0d lat=%0d", y, lat);
        check("bypass_y", y, 101);
        check("bypass_lat", lat, 6);

        // Recursion: y = x + 0.5*y1, fresh history, ch1 interleaved
        @(negedge clk); hist_clr = 1'b1;
        @(posedge clk); #1; hist_clr = 1'b0;
        write_coef(3'd0, 16'sd16384);
        write_coef(3'd3, -16'sd8192);
        commit();
        exp_imp = 10'sd256;
        for (int i = 0; i < 4; i++) begin
            sample(3'd0, (i == 0) ? 10'sd256 : 10'sd0, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
            $display("tx ch0 impulse step %0d -> y=%0d", i, y);
            check("imp_ch0", y, exp_imp);
            exp_imp = exp_imp >>> 1;
            sample(3'd1, 10'sd0, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
            $display("tx ch1 x=0 -> y=%0d ch=%0d", y, och);
            check("imp_ch1_y", y, 0);
            check("imp_ch1_ch", och, 1);
        end

        // Shadow write + commit while in MAC: in-flight keeps old b0
        sample(3'd2, 10'sd100, 1'b0, 1'b1, 16'sd8192, lat, nv, y, och, err);
        $display("tx ch2 x=100 (mid commit) -> y=%0d ch=%0d", y, och);
        check("mid_old_b0", y, 100);
        check("mid_ch", och, 2);
        sample(3'd3, 10'sd100, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch3 x=100 -> y=%0d", y);
        check("mid_new_b0", y, 50);

        // Bad channel
        sample(3'd5, 10'sd33, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch5 x=33 -> err=%0d lat=%0d", err, lat);
        check("bad_ch_err", err, 1);
        check("bad_ch_no_out", nv, 0);

        // Reset during MAC aborts the sample
        @(negedge clk);
        in_valid = 1'b1; in_ch = 3'd0; in_data = 10'sd50;
        @(posedge clk); #1; in_valid = 1'b0;
        nv_abort = 0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        if (out_valid) nv_abort++;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (out_valid) nv_abort++;
        end
        $display("tx reset abort -> out_valid pulses=%0d", nv_abort);
        check("abort_no_out", nv_abort, 0);
        sample(3'd0, 10'sd77, 1'b0, 1'b0, 16'sd0, lat, nv, y, och, err);
        $display("tx ch0 x=77 after reset -> y=%0d lat=%0d", y, lat);
        check("post_rst_pass", y, 77);
        check("post_rst_lat", lat, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
